mm1_dmem_if: RTL
================

// Module: mm1_dmem_if
// PURPOSE
//  MM1-stage data-memory access unit. Consumes the memory fields registered out of the EX->MM1
//  pipeline register and drives the SRAM-like data bus (req/addr_ok/data_ok).
//  Aligns store data and byte strobes, extracts and extends load data, and returns results to MM2.
//  Stalls the upstream stage while a transaction is outstanding, and retires accesses cancelled by a pipeline flush.
// PARAMETERS
//  (none)
// PORTS
//  clk               in   1   clock; all state updates on posedge
//  rst_n             in   1   reset, synchronous, active-low
//  mm1_valid         in   1   MM1 holds a live instruction
//  mm1_re            in   1   load request (already zeroed by flush/flush_before upstream)
//  mm1_we            in   1   store request
//  mm1_access_sz     in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  mm1_load_unsigned in   1   1: zero-extend load, 0: sign-extend
//  mm1_addr          in   32  byte address (alignment already checked upstream, ALE)
//  mm1_wdata         in   32  store data, right-justified
//  mm1_cancel        in   1   exception/ertn flush of the MM1 instruction
//  mm2_allowin       in   1   MM2 can accept a result this cycle
//  stall             out  1   freeze EX->MM1 register (drives its wen low)
//  data_sram_req     out  1   bus request
//  data_sram_wr      out  1   1 write, 0 read
//  data_sram_size    out  2   0 byte, 1 half, 2 word
//  data_sram_wstrb   out  4   byte strobes (0 for reads)
//  data_sram_addr    out  32  request address
//  data_sram_wdata   out  32  lane-replicated store data
//  data_sram_addr_ok in   1   request accepted
//  data_sram_data_ok in   1   response (read data or write ack)
//  data_sram_rdata   in   32  read data
//  mm1_done          out  1   one-cycle pulse: access retired to MM2
//  ld_data           out  32  extended load data, valid with mm1_done on loads
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched request fields 0. Reset mid-transaction abandons it.
//  States: IDLE, REQ, WAIT, DONE, DROP.
//  IDLE: start = mm1_valid & (mm1_re|mm1_we) & ~mm1_cancel. On start, latch addr/size/wr/strb/wdata/
//    unsigned -> REQ. stall = start (combinational).
//  REQ: req=1 with latched fields, held stable until addr_ok. addr_ok -> WAIT (DROP if cancelled).
//  WAIT: req=0. data_ok -> DONE (DROP: -> IDLE, response discarded). Read data latched on data_ok.
//  DONE: mm1_done = mm2_allowin. On mm2_allowin -> IDLE.
//  cancel_pend: sets on mm1_cancel in REQ/WAIT; selects the DROP path at the next transition.
//    mm1_cancel in REQ does not drop req: the request stays up until addr_ok.
//  mm1_cancel in DONE -> IDLE with no mm1_done.
//  DROP: waits for data_ok, then -> IDLE. No mm1_done. stall stays 1.
//  stall = start | REQ | WAIT | DROP | (DONE & ~mm2_allowin).
//  Minimum latency for a 0-wait bus (addr_ok in the first REQ cycle, data_ok the next cycle):
//    start cycle N, req N+1, data_ok N+2, mm1_done N+3.
//  data_ok in the same cycle as addr_ok is illegal; the bus guarantees it never occurs.
//  Strobes: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'hF.
//  wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
//  Load: r = rdata >> {a[1:0],3'b0}; byte -> ext r[7:0]; half -> ext r[15:0]; word -> rdata.
//  Low address bits are used unchecked; misalignment never reaches this block.
//  data_sram_addr carries the full address (low bits unmasked).
//  No new request is accepted until the FSM is back in IDLE: at most 1 outstanding access.
// TESTING
//  1. lb, addr=0x1003, rdata=0x80xxxxxx, 0-wait bus -> req at N+1, size=0, mm1_done at N+3, ld_data=0xFFFFFF80.
//  2. sh, addr=0x2002, wdata=0x1234ABCD -> wstrb=4'b1100, wdata=0xABCDABCD, wr=1; ld_data ignored.
//  3. lw with addr_ok held off 3 cycles -> req and addr stable throughout; stall=1 until mm1_done.
//  4. mm1_cancel during WAIT -> DROP; data_ok consumed, no mm1_done, next load issues only after IDLE.
//  5. Load completes with mm2_allowin=0 for 2 cycles -> DONE holds; ld_data stable; mm1_done on allowin.
//  6. rst_n=0 while in WAIT -> next cycle state IDLE, all outputs 0; late data_ok ignored.

Source files
------------

// File: rtl/mm1_dmem_if.sv
// mm1_dmem_if: MM1-stage data-memory access unit driving an SRAM-like req/addr_ok/data_ok bus.
// Holds at most one outstanding access; flushed accesses are drained silently through DROP.
module mm1_dmem_if (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mm1_valid,
    input  logic        mm1_re,
    input  logic        mm1_we,
    input  logic [1:0]  mm1_access_sz,
    input  logic        mm1_load_unsigned,
    input  logic [31:0] mm1_addr,
    input  logic [31:0] mm1_wdata,
    input  logic        mm1_cancel,
    input  logic        mm2_allowin,
    output logic        stall,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        mm1_done,
    output logic [31:0] ld_data
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DROP} state_t;
    state_t      state_q;
    logic        cancel_q, wr_q, uns_q;
    logic [1:0]  size_q, size_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] addr_q, wdata_q, wdata_d, ld_q, ld_d, sh;
    logic        start;

    assign start   = rst_n & (state_q == IDLE) & mm1_valid & (mm1_re | mm1_we) & ~mm1_cancel;
    assign size_d  = (mm1_access_sz == 2'b11) ? 2'd2 : mm1_access_sz;
    assign strb_d  = ~mm1_we ? 4'h0 :
                     size_d == 2'd0 ? 4'b0001 << mm1_addr[1:0] :
                     size_d == 2'd1 ? 4'b0011 << {mm1_addr[1], 1'b0} : 4'hF;
    assign wdata_d = size_d == 2'd0 ? {4{mm1_wdata[7:0]}} :
                     size_d == 2'd1 ? {2{mm1_wdata[15:0]}} : mm1_wdata;
    assign sh      = data_sram_rdata >> {addr_q[1:0], 3'b000};
    assign ld_d    = size_q == 2'd0 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
                     size_q == 2'd1 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : data_sram_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cancel_q <= 1'b0;
            wr_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= 2'd0;
            strb_q   <= 4'h0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            ld_q     <= 32'h0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q  <= REQ;
                    cancel_q <= 1'b0;
                    wr_q     <= mm1_we;
                    uns_q    <= mm1_load_unsigned;
                    size_q   <= size_d;
                    strb_q   <= strb_d;
                    addr_q   <= mm1_addr;
                    wdata_q  <= wdata_d;
                end
                // a flush cannot withdraw a request already on the bus; remember it for addr_ok
                REQ: begin
                    if (mm1_cancel) cancel_q <= 1'b1;
                    if (data_sram_addr_ok) state_q <= (cancel_q | mm1_cancel) ? DROP : WAIT;
                end
                WAIT: if (data_sram_data_ok) begin
                    state_q <= mm1_cancel ? IDLE : DONE;
                    ld_q    <= ld_d;
                end else if (mm1_cancel) state_q <= DROP;
                DONE: if (mm2_allowin | mm1_cancel) state_q <= IDLE;
                DROP: if (data_sram_data_ok) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_sram_req   = state_q == REQ;
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_wstrb = strb_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wdata = wdata_q;
    assign ld_data         = ld_q;
    assign mm1_done        = (state_q == DONE) & mm2_allowin & ~mm1_cancel;
    assign stall           = start | (state_q == REQ) | (state_q == WAIT) | (state_q == DROP) |
                             ((state_q == DONE) & ~mm2_allowin);
endmodule
